// File: rtl/draw_cmd_queue.sv
// draw_cmd_queue: command FIFO directly upstream of drawunit (clk_100m domain).
// The host pushes {command, data} entries into the queue. The block then issues them to drawunit
// one at a time, in push order, and holds each one until drawunit reports that it has finished.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   push_valid/push_ready     host handshake; push_command/push_data hold the entry
//   flush                     drops every pending entry; the command in flight is kept
//   command/data/commit       request to drawunit, held stable while commit is high
//   ack/done                  drawunit accepted / finished the current command
//   busy                      a command is in flight or the queue is non-empty
//   level                     number of pending entries (the in-flight entry is not counted)
//   done_count                number of completed commands, wraps at 16 bits
//   timeout_err               sticky; set when drawunit failed to ack or finish in time
module draw_cmd_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AW        = 3,
  parameter int unsigned CMD_BITS  = 8,
  parameter int unsigned DATA_BITS = 256,
  parameter int unsigned TIMEOUT   = 1048575
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_valid,
  output logic                 push_ready,
  input  logic [CMD_BITS-1:0]  push_command,
  input  logic [DATA_BITS-1:0] push_data,
  input  logic                 flush,
  output logic [CMD_BITS-1:0]  command,
  output logic [DATA_BITS-1:0] data,
  output logic                 commit,
  input  logic                 ack,
  input  logic                 done,
  output logic                 busy,
  output logic [AW:0]          level,
  output logic [15:0]          done_count,
  output logic                 timeout_err
);

  // The counter only has to reach TIMEOUT-1, because it holds cycles already spent in the state.
  localparam int unsigned  TW          = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimeoutLast = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FullLevel   = DEPTH[AW:0];

  typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

  state_e                          state_q, state_d;
  logic [CMD_BITS+DATA_BITS-1:0]   mem_q [DEPTH];
  logic [AW-1:0]                   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]                     level_q, level_d;
  logic                            ready_q, ready_d;
  logic [TW-1:0]                   cnt_q, cnt_d;
  logic [CMD_BITS-1:0]             command_q, command_d;
  logic [DATA_BITS-1:0]            data_q, data_d;
  logic                            commit_q, commit_d;
  logic                            busy_q, busy_d;
  logic [15:0]                     done_count_q, done_count_d;
  logic                            err_q, err_d;
  logic                            push_fire, pop, try_issue, reload, timeout_hit;

  // flush blocks a push in the same cycle, so the handshake has to see flush directly.
  assign push_ready = ready_q & ~flush;
  assign push_fire  = push_valid & push_ready;

  always_comb begin
    state_d      = state_q;
    command_d    = command_q;
    data_d       = data_q;
    commit_d     = commit_q;
    done_count_d = done_count_q;
    err_d        = err_q;
    pop          = 1'b0;
    try_issue    = 1'b0;
    reload       = 1'b0;
    timeout_hit  = (TIMEOUT != 0) && (cnt_q == TimeoutLast);

    case (state_q)
      StIdle: try_issue = 1'b1;
      StIssue: begin
        if (ack && done) begin
          // An ack with done in the same cycle counts as a full completion.
          done_count_d = done_count_q + 16'd1;
          try_issue    = 1'b1;
        end else if (ack) begin
          commit_d = 1'b0;
          state_d  = StWaitDone;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          commit_d = 1'b0;
          state_d  = StIdle;
        end
      end
      StWaitDone: begin
        if (done) begin
          done_count_d = done_count_q + 16'd1;
          try_issue    = 1'b1;
        end else if (timeout_hit) begin
          err_d    = 1'b1;
          commit_d = 1'b0;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Shared issue path: used from idle, or right after a completion so back-to-back commands
    // lose no cycle. flush takes priority over starting a new command.
    if (try_issue) begin
      if ((level_q != '0) && !flush) begin
        pop                 = 1'b1;
        {command_d, data_d} = mem_q[rd_ptr_q];
        commit_d            = 1'b1;
        state_d             = StIssue;
        reload              = 1'b1;
      end else begin
        commit_d = 1'b0;
        state_d  = StIdle;
      end
    end

    // reload also covers an ISSUE -> ISSUE transition, where the state does not change.
    cnt_d = (reload || (state_d != state_q)) ? '0 : cnt_q + TW'(1);

    wr_ptr_d = push_fire ? wr_ptr_q + 1'b1 : wr_ptr_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      level_d  = '0;
    end else begin
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      level_d  = level_q;
      case ({push_fire, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    ready_d = (level_d < FullLevel);
    busy_d  = (state_d != StIdle) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (push_fire) begin
      mem_q[wr_ptr_q] <= {push_command, push_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ready_q      <= 1'b0;
      cnt_q        <= '0;
      command_q    <= '0;
      data_q       <= '0;
      commit_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_count_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      ready_q      <= ready_d;
      cnt_q        <= cnt_d;
      command_q    <= command_d;
      data_q       <= data_d;
      commit_q     <= commit_d;
      busy_q       <= busy_d;
      done_count_q <= done_count_d;
      err_q        <= err_d;
    end
  end

  assign command     = command_q;
  assign data        = data_q;
  assign commit      = commit_q;
  assign busy        = busy_q;
  assign level       = level_q;
  assign done_count  = done_count_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_draw_cmd_queue.sv
// Randomized bench for draw_cmd_queue. The driver applies random host and drawunit traffic on
// the falling edge. It steps a transaction-level model that keeps the pending entries in a queue
// and pushes each entry the model expects to issue into a scoreboard. A separate monitor runs
// just after each rising edge: it pops the scoreboard whenever the DUT starts a command and
// compares all visible outputs with the model.
module tb_draw_cmd_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned CB    = 8;
  localparam int unsigned DB    = 256;
  localparam int unsigned TO    = 16;

  logic          clk = 1'b0;
  logic          rst, push_valid, push_ready, flush, commit, ack, done, busy, timeout_err;
  logic [CB-1:0] push_command, command;
  logic [DB-1:0] push_data, data;
  logic [AW:0]   level;
  logic [15:0]   done_count;

  always #5 clk = ~clk;

  draw_cmd_queue #(
    .DEPTH(DEPTH), .AW(AW), .CMD_BITS(CB), .DATA_BITS(DB), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_ready(push_ready),
    .push_command(push_command), .push_data(push_data), .flush(flush),
    .command(command), .data(data), .commit(commit), .ack(ack), .done(done),
    .busy(busy), .level(level), .done_count(done_count), .timeout_err(timeout_err)
  );

  typedef struct packed {
    logic [CB-1:0] cmd;
    logic [DB-1:0] dat;
  } entry_t;

  entry_t        m_pend[$];  // model: pending entries
  entry_t        sb[$];      // expected issue order
  int            m_phase;    // 0 idle, 1 waiting for ack, 2 waiting for done
  int            m_cnt;      // cycles spent waiting in the current phase
  bit            m_commit, m_err, m_rdy, m_busy;
  logic [CB-1:0] m_cmd;
  logic [DB-1:0] m_data;
  logic [15:0]   m_dc;
  int            checks = 0;
  int            failures = 0;
  bit            prev_commit = 1'b0;

  task automatic check(input string name, input logic [DB-1:0] act, input logic [DB-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Predicts the effect of one rising edge, given the inputs applied for that edge.
  task automatic model_step(input bit r, input bit pv, input bit pf, input logic [CB-1:0] pc,
                            input logic [DB-1:0] pd, input bit a, input bit d);
    bit     accept, try_issue;
    entry_t e;
    if (r) begin
      m_pend.delete();
      m_phase = 0; m_cnt = 0; m_commit = 0; m_err = 0; m_rdy = 0; m_busy = 0;
      m_cmd = '0; m_data = '0; m_dc = '0;
      return;
    end
    accept    = pv && m_rdy && !pf;
    try_issue = (m_phase == 0);
    if (m_phase == 1) begin
      if (a && d) begin m_dc++; try_issue = 1; end
      else if (a) begin m_phase = 2; m_commit = 0; m_cnt = 0; end
      else if (m_cnt == TO - 1) begin m_err = 1; m_commit = 0; m_phase = 0; end
      else m_cnt++;
    end else if (m_phase == 2) begin
      if (d) begin m_dc++; try_issue = 1; end
      else if (m_cnt == TO - 1) begin m_err = 1; m_commit = 0; m_phase = 0; end
      else m_cnt++;
    end
    if (try_issue) begin
      if (m_pend.size() > 0 && !pf) begin
        e = m_pend.pop_front();
        m_cmd = e.cmd; m_data = e.dat; m_commit = 1; m_phase = 1; m_cnt = 0;
        sb.push_back(e);
      end else begin
        m_phase = 0; m_commit = 0;
      end
    end
    if (pf) m_pend.delete();
    if (accept) begin
      e.cmd = pc; e.dat = pd;
      m_pend.push_back(e);
    end
    m_rdy  = (m_pend.size() < DEPTH);
    m_busy = (m_phase != 0) || (m_pend.size() != 0);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1; push_valid = 0; flush = 0; ack = 0; done = 0;
      model_step(1, 0, 0, '0, '0, 0, 0);
    end
  endtask

  task automatic run_phase(input int n, input int pp, input int pf, input int pa, input int pd);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst          = 0;
      push_valid   = ($urandom_range(99) < pp);
      push_command = 8'($urandom);
      for (int w = 0; w < DB / 32; w++) push_data[w*32 +: 32] = $urandom;
      flush        = ($urandom_range(99) < pf);
      ack          = ($urandom_range(99) < pa);
      done         = ($urandom_range(99) < pd);
      model_step(rst, push_valid, flush, push_command, push_data, ack, done);
    end
  endtask

  // Monitor: samples just after each rising edge, while the inputs for that edge are still applied.
  initial begin
    entry_t e;
    forever begin
      @(posedge clk);
      #2;
      if (commit === 1'b1 && (!prev_commit || (ack && done))) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL issue_unexpected: got commit=1, want no new command at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("issue_command", command, e.cmd);
          check("issue_data", data, e.dat);
        end
      end
      prev_commit = (commit === 1'b1);
      check("commit", commit, m_commit);
      check("command", command, m_cmd);
      check("level", level, m_pend.size());
      check("busy", busy, m_busy);
      check("done_count", done_count, m_dc);
      check("timeout_err", timeout_err, m_err);
      check("push_ready", push_ready, m_rdy && !flush);
    end
  end

  initial begin
    rst = 1; push_valid = 0; flush = 0; ack = 0; done = 0;
    push_command = '0; push_data = '0;
    model_step(1, 0, 0, '0, '0, 0, 0);
    do_reset(3);
    run_phase(300, 40, 0, 30, 30);   // mixed traffic
    run_phase(200, 90, 0, 0, 0);     // drawunit stalled: fill to full, repeated timeouts
    run_phase(300, 60, 8, 40, 40);   // flushes interleaved
    run_phase(200, 50, 0, 100, 100); // ack+done together: back-to-back issue
    run_phase(60, 70, 0, 40, 10);    // build a backlog waiting on done
    do_reset(2);                     // reset mid-operation
    run_phase(300, 50, 3, 20, 20);
    run_phase(300, 0, 0, 50, 50);    // drain
    @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    check("final_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
